// File: rtl/song_block_fetcher_if.sv
// rtl/song_block_fetcher_if.sv - request, table, note memory and window bus of song_block_fetcher
interface song_block_fetcher_if #(
    parameter int NOTE_W = 16,
    parameter int LANES  = 4,
    parameter int IDX_W  = 9,
    parameter int SONG_W = 2,
    parameter int ADDR_W = 12,
    parameter int SIZE_W = 3
);
    logic                      req;
    logic [IDX_W-1:0]          block_idx_in;
    logic [SONG_W-1:0]         song_sel;
    logic                      busy;
    logic                      tbl_rd_en;
    logic [SONG_W+IDX_W-1:0]   tbl_addr;
    logic [ADDR_W+SIZE_W-1:0]  tbl_data;
    logic                      note_rd_en;
    logic [ADDR_W-1:0]         note_addr;
    logic [NOTE_W-1:0]         note_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*NOTE_W-1:0]   notes;
    logic [SIZE_W-1:0]         block_size;
    logic [SIZE_W-1:0]         prev_block_size;
    logic                      size_err;

    modport slave (
        input  req, block_idx_in, song_sel, tbl_data, note_data, out_ready,
        output busy, tbl_rd_en, tbl_addr, note_rd_en, note_addr,
               out_valid, notes, block_size, prev_block_size, size_err
    );

    modport master (
        output req, block_idx_in, song_sel, tbl_data, note_data, out_ready,
        input  busy, tbl_rd_en, tbl_addr, note_rd_en, note_addr,
               out_valid, notes, block_size, prev_block_size, size_err
    );
endinterface

// File: rtl/song_block_fetcher.sv
// rtl/song_block_fetcher.sv - reads a block descriptor, fetches up to LANES notes, presents a padded window
module song_block_fetcher #(
    parameter int                NOTE_W     = 16,
    parameter int                LANES      = 4,
    parameter int                IDX_W      = 9,
    parameter int                SONG_W     = 2,
    parameter int                ADDR_W     = 12,
    parameter int                SIZE_W     = 3,
    parameter logic [NOTE_W-1:0] BLANK_NOTE = '0
) (
    input logic                 clk,
    input logic                 rst,
    song_block_fetcher_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_TBL, S_TWAIT, S_NOTE, S_DRAIN, S_OUT} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q;
    logic [SONG_W-1:0]   song_q;
    logic [ADDR_W-1:0]   start_q;
    logic [SIZE_W-1:0]   n_q;
    logic [SIZE_W-1:0]   prev_q;
    logic [SIZE_W-1:0]   cnt_q;
    logic [SIZE_W-1:0]   rd_lane_q;
    logic                rd_pend_q;
    logic                err_q;
    logic [NOTE_W-1:0]   lanes_q [LANES];

    logic [ADDR_W-1:0]       tbl_start;
    logic [SIZE_W-1:0]       tbl_size;
    logic [SIZE_W-1:0]       tbl_n;
    logic                    tbl_err;
    logic                    tbl_issue;
    logic                    note_issue;
    logic                    handshake;
    logic [LANES*NOTE_W-1:0] notes_w;

    assign {tbl_start, tbl_size} = bus.tbl_data;
    assign tbl_err = int'(tbl_size) > LANES;
    assign tbl_n   = tbl_err ? SIZE_W'(LANES) : tbl_size;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        tbl_issue  = 1'b0;
        note_issue = 1'b0;
        handshake  = 1'b0;
        case (state_q)
            S_IDLE:  if (bus.req) state_d = S_TBL;
            S_TBL: begin
                tbl_issue = 1'b1;
                state_d   = S_TWAIT;
            end
            S_TWAIT: state_d = (tbl_n == '0) ? S_OUT : S_NOTE;
            S_NOTE: begin
                note_issue = 1'b1;
                if (cnt_q == n_q - SIZE_W'(1)) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_OUT;
            S_OUT: begin
                if (bus.out_ready) begin
                    handshake = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read data returns one cycle after issue, so the lane to fill is carried in rd_lane_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q     <= '0;
            song_q    <= '0;
            start_q   <= '0;
            n_q       <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            rd_lane_q <= '0;
            rd_pend_q <= 1'b0;
            err_q     <= 1'b0;
            for (int k = 0; k < LANES; k++) lanes_q[k] <= BLANK_NOTE;
        end else begin
            rd_pend_q <= note_issue;
            rd_lane_q <= cnt_q;
            if (state_q == S_IDLE && bus.req) begin
                idx_q  <= bus.block_idx_in;
                song_q <= bus.song_sel;
            end
            if (state_q == S_TWAIT) begin
                start_q <= tbl_start;
                n_q     <= tbl_n;
                err_q   <= tbl_err;
                cnt_q   <= '0;
                for (int k = 0; k < LANES; k++) lanes_q[k] <= BLANK_NOTE;
            end
            if (note_issue) cnt_q <= cnt_q + SIZE_W'(1);
            if (rd_pend_q) begin
                for (int k = 0; k < LANES; k++)
                    if (rd_lane_q == SIZE_W'(k)) lanes_q[k] <= bus.note_data;
            end
            if (handshake) prev_q <= n_q;
        end
    end

    always_comb begin
        notes_w = '0;
        for (int k = 0; k < LANES; k++) notes_w[k*NOTE_W +: NOTE_W] = lanes_q[k];
    end

    assign bus.busy            = (state_q != S_IDLE);
    assign bus.tbl_rd_en       = tbl_issue;
    assign bus.tbl_addr        = {song_q, idx_q};
    assign bus.note_rd_en      = note_issue;
    assign bus.note_addr       = start_q + ADDR_W'(cnt_q);
    assign bus.out_valid       = (state_q == S_OUT);
    assign bus.notes           = notes_w;
    assign bus.block_size      = n_q;
    assign bus.prev_block_size = prev_q;
    assign bus.size_err        = err_q;
endmodule

// File: tb/tb_song_block_fetcher.sv
// tb/tb_song_block_fetcher.sv - randomized self-checking bench for song_block_fetcher
module tb_song_block_fetcher;
    localparam int NOTE_W = 16;
    localparam int LANES  = 4;
    localparam int IDX_W  = 9;
    localparam int SONG_W = 2;
    localparam int ADDR_W = 12;
    localparam int SIZE_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [ADDR_W+SIZE_W-1:0] tbl_mem  [2**(SONG_W+IDX_W)];
    logic [NOTE_W-1:0]        note_mem [2**ADDR_W];

    song_block_fetcher_if #(.NOTE_W(NOTE_W), .LANES(LANES), .IDX_W(IDX_W), .SONG_W(SONG_W),
                            .ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) bus ();

    song_block_fetcher #(.NOTE_W(NOTE_W), .LANES(LANES), .IDX_W(IDX_W), .SONG_W(SONG_W),
                         .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .BLANK_NOTE(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous memories with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.tbl_rd_en === 1'b1)  bus.tbl_data  <= tbl_mem[bus.tbl_addr];
        if (bus.note_rd_en === 1'b1) bus.note_data <= note_mem[bus.note_addr];
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int model_n(input logic [ADDR_W+SIZE_W-1:0] desc);
        int size = int'(desc[SIZE_W-1:0]);
        return (size > LANES) ? LANES : size;
    endfunction

    function automatic logic [LANES*NOTE_W-1:0] model_window(input logic [ADDR_W+SIZE_W-1:0] desc);
        logic [LANES*NOTE_W-1:0] w = '0;
        logic [ADDR_W-1:0] start = desc[ADDR_W+SIZE_W-1:SIZE_W];
        for (int k = 0; k < model_n(desc); k++) w[k*NOTE_W +: NOTE_W] = note_mem[start + ADDR_W'(k)];
        return w;
    endfunction

    task automatic run_fetch(input logic [SONG_W-1:0] song, input logic [IDX_W-1:0] idx,
                             input int stall, input string tag);
        logic [ADDR_W+SIZE_W-1:0] desc;
        logic [ADDR_W-1:0]        start;
        logic [LANES*NOTE_W-1:0]  exp_win;
        logic [ADDR_W-1:0]        addrs [$];
        logic                     exp_err;
        int n, c, lat;
        desc    = tbl_mem[{song, idx}];
        start   = desc[ADDR_W+SIZE_W-1:SIZE_W];
        n       = model_n(desc);
        exp_err = int'(desc[SIZE_W-1:0]) > LANES;
        exp_win = model_window(desc);
        lat     = (n == 0) ? 2 : n + 3;

        bus.song_sel     = song;
        bus.block_idx_in = idx;
        bus.out_ready    = (stall == 0);
        bus.req          = 1'b1;
        step();
        bus.req = 1'b0;
        c = 0;
        checks++;
        if (bus.busy !== 1'b1 || bus.tbl_rd_en !== 1'b1 || bus.tbl_addr !== {song, idx}) begin
            failures++;
            $display("FAIL %s table_issue: busy=%b tbl_rd_en=%b tbl_addr=%h, expected 1 1 %h",
                     tag, bus.busy, bus.tbl_rd_en, bus.tbl_addr, {song, idx});
        end
        while (bus.out_valid !== 1'b1 && c < 40) begin
            if (bus.note_rd_en === 1'b1) addrs.push_back(bus.note_addr);
            step();
            c++;
        end
        checks++;
        if (c != lat) begin
            failures++;
            $display("FAIL %s valid_latency: got %0d cycles, expected %0d", tag, c, lat);
            if (c >= 40) return;
        end
        checks++;
        if (addrs.size() != n) begin
            failures++;
            $display("FAIL %s read_count: got %0d reads, expected %0d", tag, addrs.size(), n);
        end else begin
            for (int k = 0; k < n; k++) begin
                checks++;
                if (addrs[k] !== start + ADDR_W'(k)) begin
                    failures++;
                    $display("FAIL %s note_addr[%0d]: got %h expected %h", tag, k, addrs[k], start + ADDR_W'(k));
                end
            end
        end
        checks++;
        if (bus.notes !== exp_win || bus.block_size !== SIZE_W'(n) || bus.size_err !== exp_err) begin
            failures++;
            $display("FAIL %s window: notes=%h size=%0d err=%b, expected %h %0d %b",
                     tag, bus.notes, bus.block_size, bus.size_err, exp_win, n, exp_err);
        end
        for (int s = 0; s < stall; s++) begin
            bus.req = (s % 3 == 1);
            step();
            bus.req = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.notes !== exp_win || bus.block_size !== SIZE_W'(n)) begin
                failures++;
                $display("FAIL %s stall_hold[%0d]: valid=%b busy=%b notes=%h size=%0d, expected 1 1 %h %0d",
                         tag, s, bus.out_valid, bus.busy, bus.notes, bus.block_size, exp_win, n);
            end
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.prev_block_size !== SIZE_W'(n) ||
            bus.notes !== exp_win || bus.block_size !== SIZE_W'(n) || bus.size_err !== exp_err) begin
            failures++;
            $display("FAIL %s after_handshake: valid=%b busy=%b prev=%0d notes=%h size=%0d err=%b, expected 0 0 %0d %h %0d %b",
                     tag, bus.out_valid, bus.busy, bus.prev_block_size, bus.notes, bus.block_size,
                     bus.size_err, n, exp_win, n, exp_err);
        end
    endtask

    task automatic test_reset();
        bus.req = 1'b0; bus.block_idx_in = '0; bus.song_sel = '0; bus.out_ready = 1'b0;
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.tbl_rd_en !== 1'b0 || bus.note_rd_en !== 1'b0 ||
            bus.size_err !== 1'b0 || bus.block_size !== '0 || bus.prev_block_size !== '0 ||
            bus.notes !== '0 || bus.note_addr !== '0 || bus.tbl_addr !== '0) begin
            failures++;
            $display("FAIL reset_state: valid=%b busy=%b tbl=%b note=%b err=%b size=%0d prev=%0d notes=%h na=%h ta=%h, expected all zero",
                     bus.out_valid, bus.busy, bus.tbl_rd_en, bus.note_rd_en, bus.size_err, bus.block_size,
                     bus.prev_block_size, bus.notes, bus.note_addr, bus.tbl_addr);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        tbl_mem[{2'd1, 9'd5}] = {12'h010, 3'd3};
        run_fetch(2'd1, 9'd5, 0, "basic");
        checks++;
        if (bus.notes !== 64'h0000_1012_1011_1010) begin
            failures++;
            $display("FAIL basic_notes_const: got %h expected 0000101210111010", bus.notes);
        end
    endtask

    task automatic test_zero_size();
        tbl_mem[{2'd2, 9'd17}] = {12'h3A0, 3'd0};
        run_fetch(2'd2, 9'd17, 0, "zero_size");
    endtask

    task automatic test_wrap();
        tbl_mem[{2'd0, 9'd300}] = {12'hFFE, 3'd4};
        run_fetch(2'd0, 9'd300, 1, "wrap");
    endtask

    task automatic test_oversize();
        tbl_mem[{2'd3, 9'd511}] = {12'h123, 3'd7};
        run_fetch(2'd3, 9'd511, 2, "oversize");
    endtask

    task automatic test_stall();
        tbl_mem[{2'd1, 9'd77}] = {12'($urandom), 3'd4};
        run_fetch(2'd1, 9'd77, 10, "stall");
        tbl_mem[{2'd0, 9'd78}] = {12'($urandom), 3'd2};
        run_fetch(2'd0, 9'd78, 0, "after_stall");
    endtask

    task automatic test_random();
        logic [SONG_W-1:0] song;
        logic [IDX_W-1:0]  idx;
        for (int i = 0; i < 2**ADDR_W; i++) note_mem[i] = NOTE_W'($urandom);
        for (int t = 0; t < 24; t++) begin
            song = SONG_W'($urandom);
            idx  = IDX_W'($urandom);
            tbl_mem[{song, idx}] = {ADDR_W'($urandom), SIZE_W'($urandom_range(0, 7))};
            run_fetch(song, idx, int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [LANES*NOTE_W-1:0] exp_win;
        int c = 0;
        tbl_mem[{2'd2, 9'd9}] = {12'h0F0, 3'd2};
        exp_win = model_window(tbl_mem[{2'd2, 9'd9}]);
        bus.song_sel = 2'd2; bus.block_idx_in = 9'd9; bus.out_ready = 1'b1; bus.req = 1'b1;
        while (bus.out_valid !== 1'b1 && c < 40) begin step(); c++; end
        step();
        c = 1;
        while (bus.out_valid !== 1'b1 && c < 40) begin step(); c++; end
        bus.req = 1'b0;
        checks++;
        if (c != 2 + 5 || bus.notes !== exp_win) begin
            failures++;
            $display("FAIL back_to_back: period=%0d notes=%h, expected 7 %h", c, bus.notes, exp_win);
        end
        step();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.prev_block_size !== 3'd2) begin
            failures++;
            $display("FAIL back_to_back_end: busy=%b prev=%0d, expected 0 2", bus.busy, bus.prev_block_size);
        end
    endtask

    task automatic test_reset_mid_note();
        int c = 0;
        logic seen_valid = 1'b0;
        tbl_mem[{2'd1, 9'd100}] = {12'h200, 3'd4};
        bus.song_sel = 2'd1; bus.block_idx_in = 9'd100; bus.out_ready = 1'b1; bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        while (bus.note_rd_en !== 1'b1 && c < 20) begin step(); c++; end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.note_rd_en !== 1'b0 || bus.busy !== 1'b0 || c >= 20) begin
            failures++;
            $display("FAIL reset_mid_note_strobe: note_rd_en=%b busy=%b wait=%0d, expected 0 0 <20",
                     bus.note_rd_en, bus.busy, c);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
            step();
        end
        bus.out_ready = 1'b0;
        checks++;
        if (seen_valid || bus.notes !== '0 || bus.prev_block_size !== '0 || bus.block_size !== '0) begin
            failures++;
            $display("FAIL reset_mid_note_after: valid_seen=%b notes=%h prev=%0d size=%0d, expected 0 0 0 0",
                     seen_valid, bus.notes, bus.prev_block_size, bus.block_size);
        end
    endtask

    initial begin
        for (int i = 0; i < 2**(SONG_W+IDX_W); i++) tbl_mem[i] = '0;
        for (int i = 0; i < 2**ADDR_W; i++) note_mem[i] = 16'h1000 + NOTE_W'(i);
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero_size();
        test_wrap();
        test_oversize();
        test_stall();
        test_reset_mid_note();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
